pc_unit: RTL and testbench

- Parametrised program-counter unit: the next generation of the basic PC register.
- Each enabled cycle it selects the next PC from four sources: sequential increment, PC-relative branch, absolute jump, or return-address-stack (RAS) pop.
- Call/return support comes from an internal circular RAS.
- Sits at the head of the fetch stage and drives the instruction-memory address; hazard logic stalls it via write.

---
 rtl/pc_unit.sv | 98 +++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with branch/jump/return selection and a circular return-address stack
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               INSTR_BYTES  = 4,
   parameter int               OFFSET_WIDTH = 16,
   parameter int               RAS_DEPTH    = 8
) (
   input  logic                          clk,
   input  logic                          res,
   input  logic                          write,
   input  logic                          branch_taken,
   input  logic [OFFSET_WIDTH-1:0]       branch_offset,
   input  logic                          jump,
   input  logic [WIDTH-1:0]              jump_target,
   input  logic                          call,
   input  logic                          ret,
   output logic [WIDTH-1:0]              out,
   output logic [WIDTH-1:0]              pc_seq,
   output logic [$clog2(RAS_DEPTH):0]    ras_count,
   output logic                          ras_overflow,
   output logic                          ras_underflow
);
   localparam int               PTR_W      = $clog2(RAS_DEPTH);
   localparam int               CNT_W      = PTR_W + 1;
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(INSTR_BYTES - 1));
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH-1:0] w_seq;
   logic [WIDTH-1:0] w_off;
   logic [WIDTH-1:0] w_top;
   logic [WIDTH-1:0] w_next;
   logic [PTR_W-1:0] w_top_idx;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_under;

   assign w_seq     = r_pc + WIDTH'(INSTR_BYTES);
   assign w_off     = WIDTH'($signed(branch_offset));
   assign w_top_idx = r_ptr - PTR_W'(1);
   assign w_top     = r_ras[w_top_idx];
   assign w_empty   = r_count == '0;
   assign w_full    = r_count == FULL_CNT;
   // ret outranks jump, so a ret+call never pushes
   assign w_pop     = write & ret & ~w_empty;
   assign w_under   = write & ret & w_empty;
   assign w_push    = write & ~ret & jump & call;

   // next-PC select: ret > jump > branch > sequential, targets aligned to instruction size
   always_comb begin
      w_next = ret          ? (w_empty ? w_seq : w_top) :
               jump         ? (jump_target & ALIGN_MASK) :
               branch_taken ? ((r_pc + w_off) & ALIGN_MASK) :
                              w_seq;
   end

   // PC register, stack pointer/count and sticky flags; all hold while write is low
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_pc    <= RESET_VECTOR;
         r_ptr   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (write) begin
         r_pc <= w_next;
         if (w_push) begin
            r_ptr   <= r_ptr + PTR_W'(1);
            r_count <= w_full ? r_count : r_count + CNT_W'(1);
            r_ovf   <= r_ovf | w_full;
         end else if (w_pop) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
         end
         r_unf <= r_unf | w_under;
      end
   end

   // stack storage; when full the pointer already addresses the oldest entry, so it is overwritten
   always_ff @(posedge clk) begin
      if (w_push && res) r_ras[r_ptr] <= w_seq;
   end

   assign out           = r_pc;
   assign pc_seq        = w_seq;
   assign ras_count     = r_count;
   assign ras_overflow  = r_ovf;
   assign ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit against a queue-based PC/return-stack model
module tb_pc_unit;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        write = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_offset = '0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [31:0] out;
   logic [31:0] pc_seq;
   logic [3:0]  ras_count;
   logic        ras_overflow;
   logic        ras_underflow;

   int   total = 0;
   int   bad = 0;
   logic chk_en = 1'b0;

   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic        m_ovf;
   logic        m_unf;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk(clk), .res(res), .write(write), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
      .call(call), .ret(ret), .out(out), .pc_seq(pc_seq), .ras_count(ras_count),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // one cycle of stimulus, applied at negedge; the model advances right after the sampling edge
   task automatic cyc(input logic w, input logic bt, input logic [15:0] off, input logic j,
                      input logic [31:0] jt, input logic c, input logic r);
      logic [31:0] seq;
      logic [31:0] nxt;
      write = w; branch_taken = bt; branch_offset = off;
      jump = j; jump_target = jt; call = c; ret = r;
      @(posedge clk);
      if (w) begin
         seq = m_pc + 32'd4;
         if (r) begin
            if (m_ras.size() > 0) nxt = m_ras.pop_back();
            else begin
               nxt = seq;
               m_unf = 1'b1;
            end
         end else if (j) begin
            nxt = {jt[31:2], 2'b00};
            if (c) begin
               if (m_ras.size() == D) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1'b1;
               end
               m_ras.push_back(seq);
            end
         end else if (bt) begin
            nxt = m_pc + {{16{off[15]}}, off};
            nxt[1:0] = 2'b00;
         end else nxt = seq;
         m_pc = nxt;
      end
      @(negedge clk);
   endtask

   task automatic seq_step();
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   // reset asserted between clock edges; outputs must clear without an edge
   task automatic do_reset();
      #2 res = 1'b0;
      #1;
      model_reset();
      check("async_rst_out", out, 32'h0);
      check("async_rst_cnt", 32'(ras_count), 32'h0);
      check("async_rst_ovf", 32'(ras_overflow), 32'h0);
      check("async_rst_unf", 32'(ras_underflow), 32'h0);
      @(negedge clk);
      res = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_out", out, m_pc);
         check("m_seq", pc_seq, m_pc + 32'd4);
         check("m_cnt", 32'(ras_count), 32'(m_ras.size()));
         check("m_ovf", 32'(ras_overflow), 32'(m_ovf));
         check("m_unf", 32'(ras_underflow), 32'(m_unf));
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      res = 1'b1;
      chk_en = 1'b1;
      check("rst_out", out, 32'h0);
      check("rst_cnt", 32'(ras_count), 32'h0);
      seq_step(); check("seq1", out, 32'h4);
      seq_step(); check("seq2", out, 32'h8);
      seq_step(); check("seq3", out, 32'hC);
      do_reset();

      cyc(1'b1, 1'b0, 16'h0, 1'b1, 32'h100, 1'b0, 1'b0); check("jmp100", out, 32'h100);
      cyc(1'b1, 1'b1, 16'hFFF8, 1'b0, 32'h0, 1'b0, 1'b0); check("br_neg", out, 32'hF8);
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0); check("jmp_top", out, 32'hFFFF_FFFC);
      seq_step(); check("wrap", out, 32'h0);

      cyc(1'b1, 1'b0, 16'h0, 1'b1, 32'h200, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 32'h1003, 1'b1, 1'b0);
      check("call_out", out, 32'h1000);
      check("call_cnt", 32'(ras_count), 32'h1);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("ret_out", out, 32'h204);
      check("ret_cnt", 32'(ras_count), 32'h0);

      for (int k = 0; k < 9; k++) begin
         cyc(1'b1, 1'b0, 16'h0, 1'b1, 32'(32'h10000 + k * 256), 1'b1, 1'b0);
         if (k == 7) check("ovf_before", 32'(ras_overflow), 32'h0);
      end
      check("full_cnt", 32'(ras_count), 32'h8);
      check("full_ovf", 32'(ras_overflow), 32'h1);
      for (int j = 1; j <= 8; j++) begin
         cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1);
         check("lifo", out, 32'(32'h10004 + (8 - j) * 256));
      end
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("under_out", out, 32'h10008);
      check("under_flag", 32'(ras_underflow), 32'h1);
      check("under_cnt", 32'(ras_count), 32'h0);

      cyc(1'b1, 1'b0, 16'h0, 1'b1, 32'h2000, 1'b1, 1'b0);
      check("pre_stall_cnt", 32'(ras_count), 32'h1);
      repeat (5) begin
         cyc(1'b0, 1'b1, 16'h0040, 1'b1, 32'h5000, 1'b1, 1'b1);
         check("stall_out", out, 32'h2000);
         check("stall_cnt", 32'(ras_count), 32'h1);
      end
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 32'h3000, 1'b1, 1'b1);
      check("retwin_out", out, 32'h1000C);
      check("retwin_cnt", 32'(ras_count), 32'h0);

      do_reset();
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("empty_ret_out", out, 32'h4);
      check("empty_ret_unf", 32'(ras_underflow), 32'h1);
      do_reset();
      check("unf_cleared", 32'(ras_underflow), 32'h0);

      seq_step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
